// File: rtl/sd_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_sched_if
// Requester, transmitter and status signals of the SD CMD issue scheduler.
// Revision : 1.0
// ============================================================================
interface sd_cmd_sched_if;
    logic        sw_req_i;
    logic [5:0]  sw_cmd_nr_i;
    logic [31:0] sw_arg_i;
    logic        sw_resp_exp_i;
    logic        sw_gnt_o;

    logic        auto_req_i;
    logic [5:0]  auto_cmd_nr_i;
    logic [31:0] auto_arg_i;
    logic        auto_resp_exp_i;
    logic        auto_gnt_o;

    logic        tx_start_o;
    logic [5:0]  tx_cmd_nr_o;
    logic [31:0] tx_arg_o;
    logic        tx_done_i;
    logic        resp_start_i;

    logic        busy_o;
    logic        done_o;
    logic        done_src_o;
    logic        timeout_o;
    logic        err_o;

    modport slave (
        input  sw_req_i, sw_cmd_nr_i, sw_arg_i, sw_resp_exp_i,
        input  auto_req_i, auto_cmd_nr_i, auto_arg_i, auto_resp_exp_i,
        input  tx_done_i, resp_start_i,
        output sw_gnt_o, auto_gnt_o, tx_start_o, tx_cmd_nr_o, tx_arg_o,
        output busy_o, done_o, done_src_o, timeout_o, err_o
    );

    modport master (
        output sw_req_i, sw_cmd_nr_i, sw_arg_i, sw_resp_exp_i,
        output auto_req_i, auto_cmd_nr_i, auto_arg_i, auto_resp_exp_i,
        output tx_done_i, resp_start_i,
        input  sw_gnt_o, auto_gnt_o, tx_start_o, tx_cmd_nr_o, tx_arg_o,
        input  busy_o, done_o, done_src_o, timeout_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_sched
// SD CMD-line issue scheduler: arbitrates sw/auto requesters, launches the
// transmitter, tracks the Ncr response window and enforces the Ncc gap.
// Option   : SD_CMD_SCHED_ROUND_ROBIN_EN selects round-robin arbitration.
// Revision : 1.0
// ============================================================================
module sd_cmd_sched #(
    parameter int NCR_MAX     = 64,
    parameter int GAP_CYCLES  = 8,
    parameter int START_GUARD = 4
) (
    input  wire           sd_freq_clk_i,
    input  wire           rst_i,
    sd_cmd_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_LAUNCH        = 3'd1,
        S_WAIT_TX_START = 3'd2,
        S_WAIT_TX_DONE  = 3'd3,
        S_WAIT_RESP     = 3'd4,
        S_GAP           = 3'd5
    } state_t;

    localparam logic [7:0] c_ncr_last   = 8'(NCR_MAX - 1);
    localparam logic [7:0] c_gap_last   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] c_guard_last = 8'(START_GUARD - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [5:0]  r_cmd_nr;
    logic [31:0] r_arg;
    logic        r_resp_exp;
    logic        r_src;
    logic        r_done;
    logic        r_done_src;
    logic        r_timeout;
    logic        r_err;
    logic        w_sw_gnt;
    logic        w_auto_gnt;
    logic        w_pick_auto;
    logic        w_fin;
    logic        w_tmo;
    logic        w_err;

`ifdef SD_CMD_SCHED_ROUND_ROBIN_EN
    // Points at the requester that was not served last; auto after reset.
    logic r_prio_auto;

    always_ff @(posedge sd_freq_clk_i) begin
        if (rst_i) begin
            r_prio_auto <= 1'b1;
        end else if (w_auto_gnt) begin
            r_prio_auto <= 1'b0;
        end else if (w_sw_gnt) begin
            r_prio_auto <= 1'b1;
        end
    end

    assign w_pick_auto = bus.auto_req_i && (r_prio_auto || !bus.sw_req_i);
`else
    assign w_pick_auto = bus.auto_req_i;
`endif

    always_ff @(posedge sd_freq_clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sw_gnt    = 1'b0;
        w_auto_gnt  = 1'b0;
        w_fin       = 1'b0;
        w_tmo       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst_i && (bus.auto_req_i || bus.sw_req_i)) begin
                    w_auto_gnt  = w_pick_auto;
                    w_sw_gnt    = !w_pick_auto;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT_TX_START;
            end
            S_WAIT_TX_START: begin
                if (!bus.tx_done_i) begin
                    w_state_nxt = S_WAIT_TX_DONE;
                end else if (r_cnt == c_guard_last) begin
                    w_fin       = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_WAIT_TX_DONE: begin
                if (bus.tx_done_i) begin
                    if (r_resp_exp) begin
                        w_state_nxt = S_WAIT_RESP;
                    end else begin
                        w_fin       = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_WAIT_RESP: begin
                // A start bit in the expiry cycle still counts as a response.
                if (bus.resp_start_i) begin
                    w_fin       = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == c_ncr_last) begin
                    w_fin       = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_freq_clk_i) begin
        if (rst_i) begin
            r_cnt      <= 8'd0;
            r_cmd_nr   <= 6'd0;
            r_arg      <= 32'd0;
            r_resp_exp <= 1'b0;
            r_src      <= 1'b0;
            r_done     <= 1'b0;
            r_done_src <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // One shared counter, restarted on every state change.
            if (w_state_nxt != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_auto_gnt) begin
                r_cmd_nr   <= bus.auto_cmd_nr_i;
                r_arg      <= bus.auto_arg_i;
                r_resp_exp <= bus.auto_resp_exp_i;
                r_src      <= 1'b1;
            end else if (w_sw_gnt) begin
                r_cmd_nr   <= bus.sw_cmd_nr_i;
                r_arg      <= bus.sw_arg_i;
                r_resp_exp <= bus.sw_resp_exp_i;
                r_src      <= 1'b0;
            end
            r_done     <= w_fin;
            r_done_src <= w_fin & r_src;
            r_timeout  <= w_tmo;
            r_err      <= w_err;
        end
    end

    assign bus.sw_gnt_o    = w_sw_gnt;
    assign bus.auto_gnt_o  = w_auto_gnt;
    assign bus.tx_start_o  = (r_state == S_LAUNCH);
    assign bus.tx_cmd_nr_o = r_cmd_nr;
    assign bus.tx_arg_o    = r_arg;
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.done_o      = r_done;
    assign bus.done_src_o  = r_done_src;
    assign bus.timeout_o   = r_timeout;
    assign bus.err_o       = r_err;
endmodule
`default_nettype wire
